// File: rtl/explicit_gate.sv
// explicit_gate
//   Registered three-pair AND-OR combiner:
//     y = (a & b) | (c & d) | (e & f), bitwise over WIDTH-bit operands.
//   Also reports which pair(s) produced a nonzero AND term, and counts
//   (saturating) the captures whose new result is nonzero.
//
// Build option:
//   EXPLICIT_HIT_CNT_EN  defined   -> hit_count is a CNT_W-bit saturating counter
//                        undefined -> no counter logic, hit_count tied to 0
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous active-high reset
//   en         in   1      capture enable; 0 holds every register
//   a, b       in   WIDTH  pair-0 operands
//   c, d       in   WIDTH  pair-1 operands
//   e, f       in   WIDTH  pair-2 operands
//   y          out  WIDTH  registered (a&b)|(c&d)|(e&f)
//   pair_hit   out  3      registered; bit k = |(pair k AND term)
//   hit_count  out  CNT_W  saturating count of captures with nonzero y
module explicit_gate #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] e,
  input  logic [WIDTH-1:0] f,
  output logic [WIDTH-1:0] y,
  output logic [2:0]       pair_hit,
  output logic [CNT_W-1:0] hit_count
);

  logic [WIDTH-1:0] term0;
  logic [WIDTH-1:0] term1;
  logic [WIDTH-1:0] term2;
  logic [WIDTH-1:0] y_next;
  logic [2:0]       hit_next;

  always_comb begin
    term0    = a & b;
    term1    = c & d;
    term2    = e & f;
    y_next   = term0 | term1 | term2;
    hit_next = {|term2, |term1, |term0};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y        <= '0;
      pair_hit <= '0;
    end else if (en) begin
      y        <= y_next;
      pair_hit <= hit_next;
    end
  end

`ifdef EXPLICIT_HIT_CNT_EN
  // Counts on the freshly computed result, not the registered y, so the
  // count lines up with the capture that produced the hit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count <= '0;
    end else if (en && (|y_next) && (hit_count != '1)) begin
      hit_count <= hit_count + CNT_W'(1);
    end
  end
`else
  assign hit_count = '0;
`endif

endmodule

// File: tb/tb_explicit_gate.sv
module tb_explicit_gate;

`ifdef EXPLICIT_HIT_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en  = 1'b0;

  // instance 1: WIDTH=1, CNT_W=8
  logic       a1, b1, c1, d1, e1, f1, y1;
  logic [2:0] ph1;
  logic [7:0] hc1;
  // instance 2: WIDTH=1, CNT_W=2 (saturation)
  logic       a2, b2, c2, d2, e2, f2, y2;
  logic [2:0] ph2;
  logic [1:0] hc2;
  // instance 3: WIDTH=4, CNT_W=8
  logic [3:0] a4, b4, c4, d4, e4, f4, y4;
  logic [2:0] ph4;
  logic [7:0] hc4;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  explicit_gate #(.WIDTH(1), .CNT_W(8)) u1 (
    .clk(clk), .rst(rst), .en(en),
    .a(a1), .b(b1), .c(c1), .d(d1), .e(e1), .f(f1),
    .y(y1), .pair_hit(ph1), .hit_count(hc1)
  );

  explicit_gate #(.WIDTH(1), .CNT_W(2)) u2 (
    .clk(clk), .rst(rst), .en(en),
    .a(a2), .b(b2), .c(c2), .d(d2), .e(e2), .f(f2),
    .y(y2), .pair_hit(ph2), .hit_count(hc2)
  );

  explicit_gate #(.WIDTH(4), .CNT_W(8)) u4 (
    .clk(clk), .rst(rst), .en(en),
    .a(a4), .b(b4), .c(c4), .d(d4), .e(e4), .f(f4),
    .y(y4), .pair_hit(ph4), .hit_count(hc4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] cexp(input int unsigned n);
    return CNT_ON ? n : 0;
  endfunction

  task automatic set1(input logic [5:0] v);
    {a1, b1, c1, d1, e1, f1} = v;
  endtask

  task automatic set4(input logic [3:0] va, input logic [3:0] vb, input logic [3:0] vc,
                      input logic [3:0] vd, input logic [3:0] ve, input logic [3:0] vf);
    a4 = va; b4 = vb; c4 = vc; d4 = vd; e4 = ve; f4 = vf;
  endtask

  initial begin
    // Random inputs, reset with no clock edge
    set1(6'($urandom));
    {a2, b2, c2, d2, e2, f2} = 6'($urandom);
    set4(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
    en = 1'($urandom);
    #1 rst = 1'b1;
    #1;
    check("rst_y1", 32'(y1), 0);
    check("rst_ph1", 32'(ph1), 0);
    check("rst_hc1", 32'(hc1), 0);
    check("rst_y4", 32'(y4), 0);
    check("rst_hc2", 32'(hc2), 0);
    #1 rst = 1'b0;

    en = 1'b1;
    {a2, b2, c2, d2, e2, f2} = 6'b111111;

    // step 1: a=1 d=1 only -> no pair fires
    set1(6'b100100);
    set4(4'b1100, 4'b1010, 4'b0000, 4'b0000, 4'b0001, 4'b0011);
    tick();
    check("s1_y1", 32'(y1), 0);
    check("s1_ph1", 32'(ph1), 32'b000);
    check("s1_hc1", 32'(hc1), cexp(0));
    check("s1_hc2", 32'(hc2), cexp(1));
    check("s1_y4", 32'(y4), 32'b1001);
    check("s1_ph4", 32'(ph4), 32'b101);
    check("s1_hc4", 32'(hc4), cexp(1));

    // step 2: c=1 d=1 -> pair 1 fires
    set1(6'b001100);
    set4(4'b1111, 4'b0000, 4'b0110, 4'b0011, 4'b0000, 4'b0000);
    tick();
    check("s2_y1", 32'(y1), 1);
    check("s2_ph1", 32'(ph1), 32'b010);
    check("s2_hc1", 32'(hc1), cexp(1));
    check("s2_hc2", 32'(hc2), cexp(2));
    check("s2_y4", 32'(y4), 32'b0010);
    check("s2_ph4", 32'(ph4), 32'b010);
    check("s2_hc4", 32'(hc4), cexp(2));

    // step 3: a=1 c=0 -> nothing
    set1(6'b100100);
    set4(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    tick();
    check("s3_y1", 32'(y1), 0);
    check("s3_ph1", 32'(ph1), 32'b000);
    check("s3_hc1", 32'(hc1), cexp(1));
    check("s3_hc2", 32'(hc2), cexp(3));
    check("s3_y4", 32'(y4), 0);
    check("s3_hc4", 32'(hc4), cexp(2));

    // step 4: f=1 but e=0
    set1(6'b100101);
    tick();
    check("s4_y1", 32'(y1), 0);
    check("s4_ph1", 32'(ph1), 32'b000);
    check("s4_hc2_sat", 32'(hc2), cexp(3));

    // step 5: all ones
    set1(6'b111111);
    tick();
    check("s5_y1", 32'(y1), 1);
    check("s5_ph1", 32'(ph1), 32'b111);
    check("s5_hc1", 32'(hc1), cexp(2));
    check("s5_hc2_sat", 32'(hc2), cexp(3));

    // hold with en=0 over 3 edges, inputs changed
    en = 1'b0;
    set1(6'b000000);
    {a2, b2, c2, d2, e2, f2} = 6'b000000;
    set4(4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111);
    tick(); tick(); tick();
    check("hold_y1", 32'(y1), 1);
    check("hold_ph1", 32'(ph1), 32'b111);
    check("hold_hc1", 32'(hc1), cexp(2));
    check("hold_y4", 32'(y4), 0);
    check("hold_hc4", 32'(hc4), cexp(2));

    // recapture on wide instance
    en = 1'b1;
    set4(4'b1100, 4'b1010, 4'b0000, 4'b0000, 4'b0001, 4'b0011);
    tick();
    check("re_y4", 32'(y4), 32'b1001);
    check("re_hc4", 32'(hc4), cexp(3));

    // mid-cycle asynchronous reset
    #2 rst = 1'b1;
    #1;
    check("mrst_y4", 32'(y4), 0);
    check("mrst_ph4", 32'(ph4), 0);
    check("mrst_hc4", 32'(hc4), 0);
    check("mrst_y1", 32'(y1), 0);
    check("mrst_hc2", 32'(hc2), 0);
    #1 rst = 1'b0;

    // first enabled edge after reset captures normally
    set1(6'b111111);
    {a2, b2, c2, d2, e2, f2} = 6'b000011;
    tick();
    check("post_y1", 32'(y1), 1);
    check("post_ph1", 32'(ph1), 32'b111);
    check("post_hc1", 32'(hc1), cexp(1));
    check("post_ph2", 32'(ph2), 32'b100);
    check("post_y4", 32'(y4), 32'b1001);
    check("post_hc4", 32'(hc4), cexp(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/explicit_gate.md
Name: explicit_gate

Overview:
- Registered three-pair AND-OR combiner: y = (a&b) | (c&d) | (e&f), evaluated bitwise over WIDTH-bit operands.
- Also reports which pair(s) fired and keeps a saturating count of cycles with a nonzero result.
- Used as a small decode/qualify stage feeding downstream control logic; one clock, registered outputs.

Parameters:
- WIDTH, 1, bit width of each operand a..f and of y.
- CNT_W, 8, width of the hit_count saturating counter.

Ports:
- clk  input  1  single system clock, rising-edge active.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  capture enable; when 0 all registers hold.
- a  input  WIDTH  pair-0 operand A.
- b  input  WIDTH  pair-0 operand B.
- c  input  WIDTH  pair-1 operand A.
- d  input  WIDTH  pair-1 operand B.
- e  input  WIDTH  pair-2 operand A.
- f  input  WIDTH  pair-2 operand B.
- y  output  WIDTH  registered result (a&b)|(c&d)|(e&f).
- pair_hit  output  3  registered; bit k = OR-reduction of pair k's AND term (bit0 a&b, bit1 c&d, bit2 e&f).
- hit_count  output  CNT_W  saturating count of captures with y nonzero.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high (clk, rst). On rst=1, immediately and independently of clk: y=0, pair_hit=0, hit_count=0.
- Latency: one cycle. Inputs sampled on a rising clk edge with en=1 appear on y and pair_hit after that edge.
- en=0: y, pair_hit and hit_count hold their values.
- Arithmetic: y is a pure bitwise function. No carries; bit i depends only on bit i of each operand. X/Z on inputs is not sanitized.
- pair_hit[k] = |(pair k AND term). More than one bit may be set in the same cycle.
- hit_count increments by 1 on each enabled edge where the newly computed y (not the old registered value) is nonzero.
- hit_count saturates at 2^CNT_W-1 and does not wrap.
- Reset asserted mid-operation clears everything asynchronously. After deassertion, the first enabled edge captures normally.
- Reset deassertion is synchronized externally; the block does not synchronize it internally.

Optional Feature:
- Macro EXPLICIT_HIT_CNT_EN.
- Defined: hit_count behaves as described above.
- Undefined: counter logic is not built and hit_count is tied to constant 0. y and pair_hit are unaffected.

Test Plan:
- Reset: assert rst with random inputs, no clock edge -> y=0, pair_hit=3'b000, hit_count=0 immediately.
- WIDTH=1, en=1, a=1 b=0 c=0 d=1 e=0 f=0 -> after 1 edge y=0, pair_hit=000, hit_count unchanged.
- Then a=0 c=1 (b=0 d=1 e=0 f=0) -> y=1, pair_hit=010, hit_count +1. Then a=1 c=0 -> y=0. Then f=1 -> y=0 (e=0), pair_hit=000.
- All inputs 1 -> y=1, pair_hit=111. Drop en to 0 and change inputs to all 0 -> y, pair_hit, hit_count held over 3 edges.
- CNT_W=2, y nonzero for 5 enabled edges -> hit_count 1,2,3,3,3 (saturates). Without EXPLICIT_HIT_CNT_EN -> stays 0.
- WIDTH=4: a=4'b1100 b=4'b1010 c=0 d=0 e=4'b0001 f=4'b0011 -> y=4'b1001, pair_hit=101. Assert rst mid-sequence -> all outputs 0 asynchronously.
